// File: rtl/vta_store.sv
// vta_store: drains a 2D strided region of out_mem onto a valid/ready row stream with DRAM element addresses.
// Optional VTA_STORE_PERF_EN adds the perf_stall_cycles backpressure counter output.
module vta_store #(
  parameter int INS_WIDTH       = 128,
  parameter int INP_MEM_WIDTH   = 128,
  parameter int ACC_IDX_WIDTH   = 12,
  parameter int DRAM_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INS_WIDTH-1:0]       insn,
  input  logic                       insn_valid,
  output logic                       insn_ready,
  output logic [ACC_IDX_WIDTH-1:0]   out_mem_rd_addr,
  output logic                       out_mem_rd_en,
  input  logic [INP_MEM_WIDTH-1:0]   out_mem_rd_data,
  output logic [INP_MEM_WIDTH-1:0]   st_data,
  output logic [DRAM_ADDR_WIDTH-1:0] st_addr,
  output logic                       st_last,
  output logic                       st_valid,
  input  logic                       st_ready,
  output logic                       done
`ifdef VTA_STORE_PERF_EN
  ,
  output logic [31:0]                perf_stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     r_state;
  logic [15:0]                r_xs, r_ys, r_stride, r_x, r_y;
  logic [ACC_IDX_WIDTH-1:0]   r_rd_addr;
  logic [DRAM_ADDR_WIDTH-1:0] r_dram, r_row;
  logic                       r_done;
  logic                       r_inf, r_inf_last;
  logic [DRAM_ADDR_WIDTH-1:0] r_inf_addr;
  logic [INP_MEM_WIDTH-1:0]   r_fd [2];
  logic [DRAM_ADDR_WIDTH-1:0] r_fa [2];
  logic [1:0]                 r_fl;
  logic                       r_wp, r_rp;
  logic [1:0]                 r_cnt;

  logic [2:0]  w_op;
  logic [15:0] w_sb, w_ys, w_xs, w_st;
  logic [31:0] w_db;
  logic        w_last_x, w_last, w_issue, w_empty, w_valid, w_pop, w_pop_f, w_push;
  logic [1:0]  w_cnt_nx;
  logic        w_unused;

  assign w_op = insn[2:0];
  assign w_sb = insn[24:9];
  assign w_db = insn[56:25];
  assign w_ys = insn[72:57];
  assign w_xs = insn[88:73];
  assign w_st = insn[104:89];
  assign w_unused = ^{insn[8:3], insn[INS_WIDTH-1:105], w_sb[15:ACC_IDX_WIDTH]};

  assign w_last_x = r_x == r_xs - 16'd1;
  assign w_last   = w_last_x && (r_y == r_ys - 16'd1);
  // A read may start only while FIFO entries plus the returning read leave room for it.
  assign w_issue  = (r_state == RUN) && ((r_cnt + {1'b0, r_inf}) < 2'd2);
  assign w_empty  = r_cnt == 2'd0;
  // The returning read is presented directly when the FIFO is empty, giving 1 beat/cycle.
  assign w_valid  = !w_empty || r_inf;
  assign w_pop    = w_valid && st_ready;
  assign w_pop_f  = w_pop && !w_empty;
  assign w_push   = r_inf && !(w_empty && w_pop);
  assign w_cnt_nx = r_cnt + {1'b0, w_push} - {1'b0, w_pop_f};

  assign insn_ready      = r_state == IDLE;
  assign out_mem_rd_en   = w_issue;
  assign out_mem_rd_addr = r_rd_addr;
  assign st_valid        = w_valid;
  assign st_data         = !w_empty ? r_fd[r_rp] : r_inf ? out_mem_rd_data : '0;
  assign st_addr         = !w_empty ? r_fa[r_rp] : r_inf ? r_inf_addr : '0;
  assign st_last         = !w_empty ? r_fl[r_rp] : r_inf && r_inf_last;
  assign done            = r_done;

  // Control FSM: latches the instruction and walks (y, x) with running SRAM/DRAM addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_xs      <= '0;
      r_ys      <= '0;
      r_stride  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_rd_addr <= '0;
      r_dram    <= '0;
      r_row     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (insn_valid) begin
          r_xs     <= w_xs;
          r_ys     <= w_ys;
          r_stride <= w_st;
          r_x      <= '0;
          r_y      <= '0;
          r_dram   <= w_db;
          r_row    <= w_db;
          if (w_op != 3'd1 || w_ys == 16'd0 || w_xs == 16'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= RUN;
            r_rd_addr <= w_sb[ACC_IDX_WIDTH-1:0];
          end
        end
        RUN: if (w_issue) begin
          if (w_last) begin
            r_state <= DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
            if (w_last_x) begin
              r_x    <= '0;
              r_y    <= r_y + 16'd1;
              r_row  <= r_row + DRAM_ADDR_WIDTH'(r_stride);
              r_dram <= r_row + DRAM_ADDR_WIDTH'(r_stride);
            end else begin
              r_x    <= r_x + 16'd1;
              r_dram <= r_dram + 1'b1;
            end
          end
        end
        DRAIN: if (w_cnt_nx == 2'd0) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // In-flight read: DRAM address and last flag ride alongside the BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inf      <= 1'b0;
      r_inf_addr <= '0;
      r_inf_last <= 1'b0;
    end else begin
      r_inf <= w_issue;
      if (w_issue) begin
        r_inf_addr <= r_dram;
        r_inf_last <= w_last;
      end
    end
  end

  // Two-entry row FIFO; returning data is captured unless it leaves straight through the bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fd[r_wp] <= out_mem_rd_data;
        r_fa[r_wp] <= r_inf_addr;
        r_fl[r_wp] <= r_inf_last;
        r_wp       <= ~r_wp;
      end
      if (w_pop_f)
        r_rp <= ~r_rp;
      r_cnt <= w_cnt_nx;
    end
  end

`ifdef VTA_STORE_PERF_EN
  logic [31:0] r_perf;
  assign perf_stall_cycles = r_perf;
  // Saturating count of cycles a beat waits on downstream, restarted per instruction.
  always_ff @(posedge clk) begin
    if (rst)
      r_perf <= '0;
    else if (r_state == IDLE && insn_valid)
      r_perf <= '0;
    else if (w_valid && !st_ready && r_perf != '1)
      r_perf <= r_perf + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vta_store.sv
// tb_vta_store: directed self-checking bench for vta_store with a behavioural 1-cycle out_mem.
module tb_vta_store;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] insn;
  logic         insn_valid, insn_ready;
  logic [11:0]  rd_addr;
  logic         rd_en;
  logic [127:0] rd_data, st_data;
  logic [31:0]  st_addr;
  logic         st_last, st_valid, st_ready, done;
`ifdef VTA_STORE_PERF_EN
  logic [31:0]  perf;
`endif
  int checks = 0;
  int errors = 0;
  int stall;

  vta_store dut (
    .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .out_mem_rd_addr(rd_addr), .out_mem_rd_en(rd_en), .out_mem_rd_data(rd_data),
    .st_data(st_data), .st_addr(st_addr), .st_last(st_last), .st_valid(st_valid),
    .st_ready(st_ready), .done(done)
`ifdef VTA_STORE_PERF_EN
    , .perf_stall_cycles(perf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] row(input logic [11:0] a);
    return {8{4'hA, a}};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= row(rd_addr);

  function automatic logic [127:0] mk(input logic [2:0] op, input logic [15:0] sb, input logic [31:0] db,
                                      input logic [15:0] ys, input logic [15:0] xs, input logic [15:0] st);
    logic [127:0] v;
    v = '1;
    v[2:0] = op;
    v[24:9] = sb;
    v[56:25] = db;
    v[72:57] = ys;
    v[88:73] = xs;
    v[104:89] = st;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic run_store(input string tag, input logic [2:0] op, input logic [15:0] sb, input logic [31:0] db,
                           input logic [15:0] ys, input logic [15:0] xs, input logic [15:0] st,
                           input logic [15:0] rdy_low, input int abort_at, output int stalls);
    int n, k, nrd, last_c;
    bit fin, pv;
    logic [127:0] sd;
    logic [31:0] sa, ea;
    logic sl;
    n = (op == 3'd1 && ys != 0 && xs != 0) ? int'(ys) * int'(xs) : 0;
    k = 0; nrd = 0; stalls = 0; last_c = -1; fin = 0; pv = 0;
    @(posedge clk); #1;
    insn = mk(op, sb, db, ys, xs, st);
    insn_valid = 1'b1;
    st_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".insn_ready"}, 128'(insn_ready), 128'(1));
    @(posedge clk); #1;
    insn_valid = 1'b0;
    for (int c = 1; c < 200 && !fin; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      st_ready = (c < 16) ? !rdy_low[c] : 1'b1;
      @(negedge clk);
      if (c == 1 && n > 0) chk({tag, ".rd_latency"}, 128'(rd_en), 128'(1));
      if (c == 2 && n > 0) chk({tag, ".beat_latency"}, 128'(st_valid), 128'(1));
      if (n == 0) begin
        chk({tag, ".no_rd"}, 128'(rd_en), 128'(0));
        chk({tag, ".no_beat"}, 128'(st_valid), 128'(0));
      end
      if (rd_en) begin
        chk({tag, ".rd_addr"}, 128'(rd_addr), 128'(12'(sb + 16'(nrd))));
        nrd++;
      end
      chk({tag, ".outstanding"}, 128'(nrd - k <= 2), 128'(1));
      if (pv) begin
        chk({tag, ".hold_valid"}, 128'(st_valid), 128'(1));
        chk({tag, ".hold_data"}, st_data, sd);
        chk({tag, ".hold_addr"}, 128'(st_addr), 128'(sa));
        chk({tag, ".hold_last"}, 128'(st_last), 128'(sl));
      end
      pv = 0;
      if (st_valid && st_ready) begin
        ea = db + 32'(k / int'(xs)) * 32'(st) + 32'(k % int'(xs));
        chk({tag, ".data"}, st_data, row(12'(sb + 16'(k))));
        chk({tag, ".addr"}, 128'(st_addr), 128'(ea));
        chk({tag, ".last"}, 128'(st_last), 128'(k == n - 1));
        k++;
        last_c = c;
      end else if (st_valid) begin
        stalls++;
        pv = 1;
        sd = st_data; sa = st_addr; sl = st_last;
      end
      if (k == abort_at) fin = 1;
      if (done) begin
        chk({tag, ".done_cycle"}, 128'(c), 128'(n > 0 ? last_c + 1 : 1));
        chk({tag, ".beats"}, 128'(k), 128'(n));
        chk({tag, ".reads"}, 128'(nrd), 128'(n));
        fin = 1;
      end
    end
    if (!fin) chk({tag, ".timeout"}, 128'(0), 128'(1));
    if (abort_at < 0) begin
      @(negedge clk);
      chk({tag, ".done_pulse"}, 128'(done), 128'(0));
      chk({tag, ".idle_ready"}, 128'(insn_ready), 128'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; insn = '0; insn_valid = 1'b0; st_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.rd_en", 128'(rd_en), 128'(0));
    chk("reset.rd_addr", 128'(rd_addr), 128'(0));
    chk("reset.st_valid", 128'(st_valid), 128'(0));
    chk("reset.st_data", st_data, 128'(0));
    chk("reset.st_addr", 128'(st_addr), 128'(0));
    chk("reset.st_last", 128'(st_last), 128'(0));
    chk("reset.done", 128'(done), 128'(0));
    chk("reset.insn_ready", 128'(insn_ready), 128'(1));
`ifdef VTA_STORE_PERF_EN
    chk("reset.perf", 128'(perf), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    run_store("basic", 3'd1, 16'h0010, 32'h1000, 16'd1, 16'd4, 16'd4, 16'h0000, -1, stall);
    chk("basic.stalls", 128'(stall), 128'(0));
`ifdef VTA_STORE_PERF_EN
    chk("basic.perf", 128'(perf), 128'(0));
`endif
    run_store("stride2d", 3'd1, 16'h0020, 32'h0, 16'd2, 16'd3, 16'd8, 16'h0000, -1, stall);
    run_store("bp", 3'd1, 16'h0020, 32'h0, 16'd2, 16'd3, 16'd8, 16'b0000_0011_1111_0100, -1, stall);
    chk("bp.stalls", 128'(stall), 128'(7));
`ifdef VTA_STORE_PERF_EN
    chk("bp.perf", 128'(perf), 128'(7));
`endif
    run_store("x0", 3'd1, 16'h0030, 32'h100, 16'd2, 16'd0, 16'd4, 16'h0000, -1, stall);
`ifdef VTA_STORE_PERF_EN
    chk("x0.perf_clear", 128'(perf), 128'(0));
`endif
    run_store("nop", 3'd0, 16'h0030, 32'h100, 16'd2, 16'd2, 16'd4, 16'h0000, -1, stall);
    run_store("wrap", 3'd1, 16'h0FFE, 32'h20, 16'd1, 16'd4, 16'd4, 16'h0000, -1, stall);

    run_store("midrst", 3'd1, 16'h0100, 32'h4000, 16'd4, 16'd4, 16'd4, 16'h0000, 3, stall);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.rd_en", 128'(rd_en), 128'(0));
    chk("midrst.rd_addr", 128'(rd_addr), 128'(0));
    chk("midrst.st_valid", 128'(st_valid), 128'(0));
    chk("midrst.st_data", st_data, 128'(0));
    chk("midrst.st_addr", 128'(st_addr), 128'(0));
    chk("midrst.st_last", 128'(st_last), 128'(0));
    chk("midrst.done", 128'(done), 128'(0));
    chk("midrst.insn_ready", 128'(insn_ready), 128'(1));
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst.quiet_done", 128'(done), 128'(0));
      chk("midrst.quiet_valid", 128'(st_valid), 128'(0));
    end
    run_store("after_rst", 3'd1, 16'h0040, 32'h2000, 16'd2, 16'd2, 16'd16, 16'h0000, -1, stall);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
